// File: rtl/dram16_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dram16_fifo_ctrl
//
// Purpose:
//   Pointer and flag controller that turns a 16-deep dual-port distributed RAM
//   (DRAM16XN) into a single-clock show-ahead FIFO. Data moves directly between
//   the client and the RAM. This block only drives the RAM addresses and the
//   write enable, and it reports occupancy and status flags.
//
// Optional feature macro:
//   DRAM16_FIFO_ERR_STICKY_EN - when defined, OVERFLOW and UNDERFLOW are sticky
//   error flags. A write request while full sets OVERFLOW. A read request while
//   empty sets UNDERFLOW. Both clear on FLUSH or reset. When the macro is not
//   defined, both outputs are tied to 0 and no flag registers exist.
//
// Parameters:
//   AFULL_THRESH  (1..15) ALMOST_FULL  when occupancy >= threshold
//   AEMPTY_THRESH (0..14) ALMOST_EMPTY when occupancy <= threshold
//
// Ports:
//   CLK          in   single clock, also the RAM write clock
//   RESET_N      in   asynchronous active-low reset
//   FLUSH        in   synchronous clear of pointers, count and error flags
//   WR_REQ       in   client write request
//   WR_ACCEPT    out  write taken this cycle
//   RD_REQ       in   client pops the head entry
//   RD_ACCEPT    out  pop taken this cycle
//   RD_VALID     out  head entry valid on the RAM DP output
//   RAM_WADDR    out  RAM write address (write pointer)
//   RAM_RADDR    out  RAM DP read address (read pointer)
//   RAM_WE       out  RAM write enable
//   COUNT        out  occupancy 0..16
//   FULL/EMPTY/ALMOST_FULL/ALMOST_EMPTY  out  registered occupancy flags
//   OVERFLOW/UNDERFLOW                   out  sticky error flags (optional)
// -----------------------------------------------------------------------------
module dram16_fifo_ctrl #(
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       FLUSH,
  input  logic       WR_REQ,
  output logic       WR_ACCEPT,
  input  logic       RD_REQ,
  output logic       RD_ACCEPT,
  output logic       RD_VALID,
  output logic [3:0] RAM_WADDR,
  output logic [3:0] RAM_RADDR,
  output logic       RAM_WE,
  output logic [4:0] COUNT,
  output logic       FULL,
  output logic       EMPTY,
  output logic       ALMOST_FULL,
  output logic       ALMOST_EMPTY,
  output logic       OVERFLOW,
  output logic       UNDERFLOW
);

  localparam logic [4:0] DEPTH     = 5'd16;
  localparam logic [4:0] AFULL_LVL = 5'(AFULL_THRESH);
  localparam logic [4:0] AEMPT_LVL = 5'(AEMPTY_THRESH);

  logic [3:0] wptr_q, wptr_d;
  logic [3:0] rptr_q, rptr_d;
  logic [4:0] count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       afull_q, afull_d;
  logic       aempty_q, aempty_d;
  logic       wr_acc;
  logic       rd_acc;

  // Accepts are gated by the registered flags. A pop at full, or a push at
  // empty, therefore affects only the side that is allowed. There is no
  // same-cycle bypass from write to read.
  assign wr_acc = WR_REQ & ~full_q  & ~FLUSH;
  assign rd_acc = RD_REQ & ~empty_q & ~FLUSH;

  assign WR_ACCEPT = wr_acc;
  assign RAM_WE    = wr_acc;
  assign RD_ACCEPT = rd_acc;
  assign RD_VALID  = ~empty_q;

  assign RAM_WADDR = wptr_q;
  assign RAM_RADDR = rptr_q;
  assign COUNT     = count_q;

  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (FLUSH) begin
      wptr_d  = 4'd0;
      rptr_d  = 4'd0;
      count_d = 5'd0;
    end else begin
      // Pointers wrap 15->0 through natural 4-bit overflow. Full and empty
      // come from the count only, never from pointer equality.
      if (wr_acc) wptr_d = wptr_q + 4'd1;
      if (rd_acc) rptr_d = rptr_q + 4'd1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are registered from the next-state count so that they line up with
  // COUNT in the same cycle.
  always_comb begin
    full_d   = (count_d == DEPTH);
    empty_d  = (count_d == 5'd0);
    afull_d  = (count_d >= AFULL_LVL);
    aempty_d = (count_d <= AEMPT_LVL);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q   <= 4'd0;
      rptr_q   <= 4'd0;
      count_q  <= 5'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

`ifdef DRAM16_FIFO_ERR_STICKY_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // FLUSH takes priority over a new error raised in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (FLUSH) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (WR_REQ & full_q)  ovf_d = 1'b1;
      if (RD_REQ & empty_q) unf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: doc/dram16_fifo_ctrl.md
Name: dram16_fifo_ctrl

Overview:
- Pointer and flag controller that turns a 16-deep dual-port distributed RAM (DRAM16XN, any data_width) into a single-clock show-ahead FIFO.
- Drives the RAM write address, write enable and read (DP) address. Data flows directly between the client and the RAM; it does not pass through this block.
- Used in the HDMI pixel path as an elastic and deskew buffer between the video source and the TMDS encoder.

Parameters:
- AFULL_THRESH, 12: ALMOST_FULL asserts when occupancy >= this value (legal range 1..15).
- AEMPTY_THRESH, 2: ALMOST_EMPTY asserts when occupancy <= this value (legal range 0..14).

Ports:
- CLK  in  1  single clock; also the RAM write clock.
- RESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of pointers and count.
- WR_REQ  in  1  client requests a write this cycle.
- WR_ACCEPT  out  1  write taken this cycle.
- RD_REQ  in  1  client pops the head entry this cycle.
- RD_ACCEPT  out  1  pop taken this cycle.
- RD_VALID  out  1  head entry valid on RAM O_DATA_OUT_DP.
- RAM_WADDR  out  4  to RAM ADDRESS.
- RAM_RADDR  out  4  to RAM ADDRESS_DP.
- RAM_WE  out  1  to RAM WRITE_EN.
- COUNT  out  5  occupancy, 0..16.
- FULL  out  1  COUNT == 16.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  see AFULL_THRESH.
- ALMOST_EMPTY  out  1  see AEMPTY_THRESH.
- OVERFLOW  out  1  sticky error flag (optional feature).
- UNDERFLOW  out  1  sticky error flag (optional feature).

Behaviour:
- Reset (RESET_N low, asynchronous): wptr=0, rptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0. Deassertion is synchronous to CLK.
- State: 4-bit wptr, 4-bit rptr, 5-bit count. All flags are registered, derived from the next-state count.
- RAM_WADDR = wptr; RAM_RADDR = rptr. Both are plain register outputs.
- Write path:
  - WR_ACCEPT = RAM_WE = WR_REQ & ~FULL & ~FLUSH (combinational).
  - On WR_ACCEPT, wptr increments mod 16 at the clock edge.
- Read path (show-ahead):
  - RD_VALID = ~EMPTY.
  - The head word is available on the RAM DPO with zero latency.
  - RD_ACCEPT = RD_REQ & ~EMPTY & ~FLUSH.
  - On RD_ACCEPT, rptr increments mod 16.
- Latency: a word written in cycle N is visible at the head, with EMPTY=0 and RD_VALID=1, in cycle N+1. A pop frees space the following cycle.
- Count update: count_next = count + WR_ACCEPT - RD_ACCEPT.
  - Simultaneous accepted read and write leaves count unchanged; both pointers advance.
- Full boundary: with FULL=1, WR_REQ is ignored (no RAM_WE). A concurrent RD_REQ pops, giving COUNT=15 next cycle.
- Empty boundary: with EMPTY=1, RD_REQ is ignored. A concurrent WR_REQ writes, giving COUNT=1 next cycle. There is no same-cycle bypass.
- Wrap-around: pointers roll over 15->0 silently. Full and empty are distinguished by count only, never by pointer equality.
- FLUSH (synchronous, highest priority):
  - Next cycle: wptr=rptr=0, COUNT=0, EMPTY=1.
  - Blocks accepts in the FLUSH cycle.
  - Clears sticky error flags.
- Reset mid-transfer: any in-flight write in that cycle is lost and pointers clear immediately. RAM contents are not cleared and are unspecified to the client.

Optional Feature:
- Macro: DRAM16_FIFO_ERR_STICKY_EN.
- Defined:
  - OVERFLOW sets on WR_REQ & FULL.
  - UNDERFLOW sets on RD_REQ & EMPTY.
  - Both hold until FLUSH or reset; registered, visible the cycle after the offending request.
- Undefined: OVERFLOW and UNDERFLOW are tied to 0 and no flag registers are synthesized.

Test Plan:
- Reset, then write 16 words 0x00..0x0F in consecutive cycles -> COUNT=16, FULL=1, ALMOST_FULL set at COUNT=12. A 17th WR_REQ gives WR_ACCEPT=0, RAM_WE=0, OVERFLOW=1 next cycle (macro on).
- Drain 16 pops from full -> head data 0x00..0x0F in order, EMPTY=1 after last pop. A further RD_REQ gives RD_ACCEPT=0, UNDERFLOW=1 (macro on), 0 (macro off).
- Continuous simultaneous WR_REQ/RD_REQ at COUNT=8 for 40 cycles -> COUNT stays 8, pointers wrap 15->0 at least twice, data order preserved.
- At FULL, assert WR_REQ and RD_REQ together -> RD_ACCEPT=1, WR_ACCEPT=0, COUNT=15. At EMPTY, assert both -> WR_ACCEPT=1, RD_ACCEPT=0, COUNT=1, RD_VALID=1 the following cycle.
- At COUNT=5 with a sticky flag set, assert FLUSH together with WR_REQ -> no RAM_WE; next cycle COUNT=0, RAM_WADDR=RAM_RADDR=0, flags cleared.
- Drop RESET_N asynchronously mid-cycle at COUNT=10 -> all outputs return to reset values immediately, without waiting for a CLK edge.
